// File: rtl/db_mv_pkg.sv
// db_mv_pkg: constants and types shared by the deblocking top-MV line-buffer
// controller and its bench.
//   MV_WIDTH / MV_NUM / MV_IDX_W : stored MV word width, words per LCU, log2.
//   state_e                      : controller FSM states.
//   MEM_ENA / MEM_DIS            : active-low RAM enable levels.
//   mv_vec_t                     : one LCU worth of MVs, entry k = [k].
package db_mv_pkg;
  localparam int MV_WIDTH = 20;
  localparam int MV_NUM   = 8;
  localparam int MV_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic MEM_ENA = 1'b0;
  localparam logic MEM_DIS = 1'b1;

  typedef logic [MV_NUM-1:0][MV_WIDTH-1:0] mv_vec_t;
endpackage

// File: rtl/db_mv_top_ctrl.sv
// db_mv_top_ctrl: per-LCU controller for the deblocking top-MV line buffer.
// For each LCU it reads the eight top-neighbour MVs left by the LCU row above
// (entries {lcu_x, 0..7}) and then overwrites them with this LCU's bottom-row
// MVs for the next row. Drives every port of the single-port MV RAM.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           one-cycle LCU start, ignored while busy_o
//   lcu_x_i           LCU column index (sampled with start_i)
//   first_row_i       picture row 0, no top neighbour: skip the read phase
//   last_row_i        (DB_MV_LAST_ROW_SKIP_EN only) skip the write phase
//   bot_mv_i          bottom-row MVs, entry k at [k*20 +: 20]
//   busy_o, done_o    operation in progress / one-cycle completion pulse
//   top_vld_o         top_mv_o holds neighbour data for the current LCU
//   top_mv_o          fetched top MVs, same packing as bot_mv_i
//   mem_*             RAM address, active-low rd/wr enables, write data,
//                     read data (valid the cycle after the read)
//
// Optional build macro: DB_MV_LAST_ROW_SKIP_EN adds last_row_i.
module db_mv_top_ctrl
  import db_mv_pkg::*;
#(
  parameter int PIC_X_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [PIC_X_WIDTH-1:0]        lcu_x_i,
  input  logic                          first_row_i,
`ifdef DB_MV_LAST_ROW_SKIP_EN
  input  logic                          last_row_i,
`endif
  input  logic [MV_NUM*MV_WIDTH-1:0]    bot_mv_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          top_vld_o,
  output logic [MV_NUM*MV_WIDTH-1:0]    top_mv_o,
  output logic [PIC_X_WIDTH+MV_IDX_W-1:0] mem_adr_o,
  output logic                          mem_rd_ena_o,
  output logic                          mem_wr_ena_o,
  output logic [MV_WIDTH-1:0]           mem_wr_dat_o,
  input  logic [MV_WIDTH-1:0]           mem_rd_dat_i
);

  localparam logic [MV_IDX_W-1:0] CNT_LAST = MV_IDX_W'(MV_NUM - 1);

  state_e                 state_q, state_d;
  logic [MV_IDX_W-1:0]    cnt_q, cnt_d;
  logic [PIC_X_WIDTH-1:0] lcu_x_q, lcu_x_d;
  mv_vec_t                bot_mv_q, bot_mv_d;
  mv_vec_t                top_mv_q, top_mv_d;
  logic                   top_vld_q, top_vld_d;
  logic [MV_IDX_W-1:0]    rd_slot;
  logic                   skip_new;   // skip writes for the LCU being started
  logic                   skip_cur;   // skip writes for the LCU in flight

`ifdef DB_MV_LAST_ROW_SKIP_EN
  logic last_row_q, last_row_d;

  always_comb begin
    last_row_d = last_row_q;
    if (state_q == ST_IDLE && start_i) last_row_d = last_row_i;
  end

  always_ff @(posedge clk) begin
    if (rst) last_row_q <= 1'b0;
    else     last_row_q <= last_row_d;
  end

  assign skip_new = last_row_i;
  assign skip_cur = last_row_q;
`else
  assign skip_new = 1'b0;
  assign skip_cur = 1'b0;
`endif

  // Read data lags its address by one cycle, so the word landing now belongs
  // to the previous count.
  assign rd_slot = cnt_q - MV_IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcu_x_d   = lcu_x_q;
    bot_mv_d  = bot_mv_q;
    top_mv_d  = top_mv_q;
    top_vld_d = top_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lcu_x_d   = lcu_x_i;
          bot_mv_d  = bot_mv_i;
          top_mv_d  = '0;
          top_vld_d = 1'b0;
          cnt_d     = '0;
          // first_row only steers this transition, so it is not stored.
          if (!first_row_i)  state_d = ST_RD;
          else if (skip_new) state_d = ST_DONE;
          else               state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (cnt_q != '0) top_mv_d[rd_slot] = mem_rd_dat_i;
        cnt_d = cnt_q + MV_IDX_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        top_mv_d[CNT_LAST] = mem_rd_dat_i;
        top_vld_d          = 1'b1;
        cnt_d              = '0;
        state_d            = skip_cur ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        cnt_d = cnt_q + MV_IDX_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lcu_x_q   <= '0;
      bot_mv_q  <= '0;
      top_mv_q  <= '0;
      top_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcu_x_q   <= lcu_x_d;
      bot_mv_q  <= bot_mv_d;
      top_mv_q  <= top_mv_d;
      top_vld_q <= top_vld_d;
    end
  end

  // RAM controls decode straight from state so a reset drops them at once.
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign top_vld_o    = top_vld_q;
  assign top_mv_o     = top_mv_q;
  assign mem_adr_o    = {lcu_x_q, cnt_q};
  assign mem_rd_ena_o = (state_q == ST_RD) ? MEM_ENA : MEM_DIS;
  assign mem_wr_ena_o = (state_q == ST_WR) ? MEM_ENA : MEM_DIS;
  assign mem_wr_dat_o = (state_q == ST_WR) ? bot_mv_q[cnt_q] : '0;

endmodule

// File: tb/tb_db_mv_top_ctrl.sv
// Bench for db_mv_top_ctrl: a behavioural 512x20 RAM, directed LCU sequences,
// and a scoreboard of expected RAM reads/writes and done pulses (with cycle
// stamps) popped by a negedge monitor.
`timescale 1ns/1ps
module tb_db_mv_top_ctrl;
  import db_mv_pkg::*;

  localparam int XW = 6;
  localparam int EV_RD = 0, EV_WR = 1, EV_DONE = 2;

  typedef struct {
    int                  kind;
    int                  cyc;
    int                  adr;
    logic [MV_WIDTH-1:0] dat;
    logic                vld;
    mv_vec_t             top;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start_i = 1'b0;
  logic                  first_row_i = 1'b0;
`ifdef DB_MV_LAST_ROW_SKIP_EN
  logic                  last_row_i = 1'b0;
`endif
  logic [XW-1:0]         lcu_x_i = '0;
  mv_vec_t               bot_mv_i = '0;
  logic                  busy_o, done_o, top_vld_o;
  mv_vec_t               top_mv_o;
  logic [XW+2:0]         mem_adr_o;
  logic                  mem_rd_ena_o, mem_wr_ena_o;
  logic [MV_WIDTH-1:0]   mem_wr_dat_o;
  logic [MV_WIDTH-1:0]   rd_dat_q = '0;
  logic [MV_WIDTH-1:0]   ram [0:511];
  logic                  seed_req = 1'b0;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  q[$];

  db_mv_top_ctrl #(.PIC_X_WIDTH(XW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .lcu_x_i      (lcu_x_i),
    .first_row_i  (first_row_i),
`ifdef DB_MV_LAST_ROW_SKIP_EN
    .last_row_i   (last_row_i),
`endif
    .bot_mv_i     (bot_mv_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .top_vld_o    (top_vld_o),
    .top_mv_o     (top_mv_o),
    .mem_adr_o    (mem_adr_o),
    .mem_rd_ena_o (mem_rd_ena_o),
    .mem_wr_ena_o (mem_wr_ena_o),
    .mem_wr_dat_o (mem_wr_dat_o),
    .mem_rd_dat_i (rd_dat_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MV_WIDTH-1:0] seed(int a);
    return 20'hA0000 | MV_WIDTH'(a);
  endfunction

  function automatic mv_vec_t mk(int base);
    mv_vec_t v;
    for (int k = 0; k < MV_NUM; k++) v[k] = MV_WIDTH'(base + k);
    return v;
  endfunction

  function automatic mv_vec_t mk_seed(int a0);
    mv_vec_t v;
    for (int k = 0; k < MV_NUM; k++) v[k] = seed(a0 + k);
    return v;
  endfunction

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (seed_req) begin
      for (int i = 0; i < 512; i++) ram[i] <= seed(i);
    end else begin
      if (!mem_wr_ena_o) ram[mem_adr_o] <= mem_wr_dat_o;
      if (!mem_rd_ena_o) rd_dat_q <= ram[mem_adr_o];
    end
  end

  task automatic observe(int kind, int adr, logic [MV_WIDTH-1:0] dat, logic vld, mv_vec_t top);
    ev_t e;
    n_vec++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d adr=%0d", kind, cyc, adr);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.adr != adr ||
          (kind == EV_WR && e.dat !== dat) ||
          (kind == EV_DONE && (e.vld !== vld || e.top !== top))) begin
        n_err++;
        $display("FAIL event got kind=%0d cyc=%0d adr=%0d dat=%h vld=%b top=%h exp kind=%0d cyc=%0d adr=%0d dat=%h vld=%b top=%h",
                 kind, cyc, adr, dat, vld, top, e.kind, e.cyc, e.adr, e.dat, e.vld, e.top);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_rd_ena_o && !mem_wr_ena_o) begin
        n_err++;
        $display("FAIL rd_wr_overlap cyc=%0d adr=%0d", cyc, mem_adr_o);
      end
      if (!mem_rd_ena_o) observe(EV_RD, int'(mem_adr_o), '0, 1'b0, '0);
      if (!mem_wr_ena_o) observe(EV_WR, int'(mem_adr_o), mem_wr_dat_o, 1'b0, '0);
      if (done_o)        observe(EV_DONE, int'(mem_adr_o), '0, top_vld_o, top_mv_o);
    end
  end

  task automatic check(string nm, logic [MV_NUM*MV_WIDTH-1:0] got, logic [MV_NUM*MV_WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"},  busy_o,       '0);
    check({tag, "_done"},  done_o,       '0);
    check({tag, "_vld"},   top_vld_o,    '0);
    check({tag, "_top"},   top_mv_o,     '0);
    check({tag, "_adr"},   mem_adr_o,    '0);
    check({tag, "_rd"},    mem_rd_ena_o, 1);
    check({tag, "_wr"},    mem_wr_ena_o, 1);
    check({tag, "_wdat"},  mem_wr_dat_o, '0);
  endtask

  // Expected event stream for one LCU whose start is sampled at the edge
  // closing cycle t.
  task automatic push_op(int t, int x, logic fr, logic lr, mv_vec_t bot, mv_vec_t top);
    ev_t e;
    int  base = x * 8;
    int  rdlen = fr ? 0 : 9;
    if (!fr)
      for (int k = 0; k < MV_NUM; k++) begin
        e = '{EV_RD, t + 1 + k, base + k, '0, 1'b0, '0};
        q.push_back(e);
      end
    if (!lr)
      for (int k = 0; k < MV_NUM; k++) begin
        e = '{EV_WR, t + 1 + rdlen + k, base + k, bot[k], 1'b0, '0};
        q.push_back(e);
      end
    e = '{EV_DONE, t + 1 + rdlen + (lr ? 0 : 8), base, '0, !fr, fr ? '0 : top};
    q.push_back(e);
  endtask

  task automatic start_op(logic [XW-1:0] x, logic fr, logic lr, mv_vec_t bot, output int t);
    @(negedge clk);
    lcu_x_i     = x;
    first_row_i = fr;
`ifdef DB_MV_LAST_ROW_SKIP_EN
    last_row_i  = lr;
`else
    if (lr) $display("note: last_row ignored in this build");
`endif
    bot_mv_i    = bot;
    start_i     = 1'b1;
    t           = cyc;
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    bot_mv_i = ~bot;   // later input changes must not reach the latched copy
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((q.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL timeout pending=%0d busy=%0b", q.size(), busy_o);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int      t;
    mv_vec_t b1, b2, b3, b5;
    b1 = mk('h100);
    b2 = mk('h200);
    b3 = mk('h300);
    b5 = mk('h500);

    // Reset state, RAM seeded with seed(a).
    seed_req = 1'b1;
    @(negedge clk);
    seed_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    #1 rst = 1'b0;

    // First row: writes only, entries 40..47.
    start_op(5, 1'b1, 1'b0, b1, t);
    push_op(t, 5, 1'b1, 1'b0, b1, '0);
    wait_idle(40);
    for (int k = 0; k < MV_NUM; k++) check("ram_first_row", ram[40 + k], b1[k]);

    // Second row: read back what the first row left, then overwrite.
    start_op(5, 1'b0, 1'b0, b2, t);
    push_op(t, 5, 1'b0, 1'b0, b2, b1);
    repeat (9) @(negedge clk);
    check("top_vld_c9", top_vld_o, 0);
    @(negedge clk);
    check("top_vld_c10", top_vld_o, 1);
    check("top_mv_c10", top_mv_o, b1);
    wait_idle(40);
    check("top_vld_held", top_vld_o, 1);

    // Back-to-back with start held high, column 63 (addresses 504..511).
    @(negedge clk);
    lcu_x_i     = 6'd63;
    first_row_i = 1'b0;
    bot_mv_i    = b3;
    start_i     = 1'b1;
    t           = cyc;
    push_op(t,      63, 1'b0, 1'b0, b3, mk_seed(504));
    push_op(t + 19, 63, 1'b0, 1'b0, b3, b3);
    push_op(t + 38, 63, 1'b0, 1'b0, b3, b3);
    repeat (40) @(negedge clk);
    start_i = 1'b0;
    wait_idle(100);
    check("ram_wrap_0", ram[0], seed(0));
    for (int k = 0; k < MV_NUM; k++) check("ram_wrap", ram[504 + k], b3[k]);

    // Reset in the middle of a write phase: entries 0..3 land, 4..7 do not.
    start_op(2, 1'b1, 1'b0, b5, t);
    for (int k = 0; k < 4; k++) begin
      ev_t e;
      e = '{EV_WR, t + 1 + k, 16 + k, b5[k], 1'b0, '0};
      q.push_back(e);
    end
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midwr_rst");
    @(negedge clk);
    check("midwr_rst2_wr", mem_wr_ena_o, 1);
    check("midwr_rst2_busy", busy_o, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midwr_pending", q.size(), 0);
    for (int k = 0; k < 4; k++) check("ram_midwr_done", ram[16 + k], b5[k]);
    for (int k = 4; k < 8; k++) check("ram_midwr_kept", ram[16 + k], seed(16 + k));

`ifdef DB_MV_LAST_ROW_SKIP_EN
    // Last row: reads only; first+last row: straight to done.
    start_op(5, 1'b0, 1'b1, b3, t);
    push_op(t, 5, 1'b0, 1'b1, b3, b2);
    wait_idle(40);
    for (int k = 0; k < MV_NUM; k++) check("ram_lastrow_kept", ram[40 + k], b2[k]);
    start_op(7, 1'b1, 1'b1, b3, t);
    push_op(t, 7, 1'b1, 1'b1, b3, '0);
    wait_idle(40);
    for (int k = 0; k < MV_NUM; k++) check("ram_firstlast_kept", ram[56 + k], seed(56 + k));
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
